// File: rtl/lenet_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : lenet_pkg                                               |
// | Purpose  : Shared constants and types for the LeNet layer          |
// |            sequencers (F6 sizes, W6 ROM geometry, FSM encoding,    |
// |            valid/tag pipe entry layout).                           |
// | Ports    : none (package)                                          |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package lenet_pkg;

  localparam int F6_N_IN    = 120;  // C5 features feeding F6
  localparam int F6_N_OUT   = 84;   // F6 accumulators / weights per ROM word
  localparam int W6_AW      = 7;    // W6 ROM / C5 buffer address width
  localparam int W6_DW      = 672;  // 84 x 8-bit weights per ROM word
  localparam int W6_ROM_LAT = 2;    // address-to-data latency of the W6 ROM

  // Controller state encoding (shared by the layer sequencers)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // One entry of the ROM-latency valid pipe
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } vtag_t;

  localparam int VTAG_W = $bits(vtag_t);

endpackage
`default_nettype wire

// File: rtl/valid_tag_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : valid_tag_pipe                                          |
// | Purpose  : DEPTH-deep shift register of {valid, first, last} tags  |
// |            that tracks data through a read-latency pipeline.       |
// |            hold=1 freezes every stage (upstream/downstream stall). |
// | Ports    : clk, rst_n (async, active-low), hold, din[W], dout[W]   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module valid_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (!hold) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/f6_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : f6_ctrl                                                 |
// | Purpose  : Sequencer for the F6 fully-connected layer. Walks the   |
// |            N_IN C5 feature indices, driving the W6 ROM and C5      |
// |            buffer addresses in lockstep, and emits MAC controls    |
// |            delayed by ROM_LAT to line up with the returned data.   |
// | Ports    : clk, rst_n (async, active-low), start, stall            |
// |            busy, done, w6_raddr[AW], w6_en, x_raddr[AW], x_en,     |
// |            mac_en, mac_clr, mac_last                               |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module f6_ctrl
  import lenet_pkg::*;
#(
  parameter int N_IN    = F6_N_IN,
  parameter int AW      = W6_AW,
  parameter int ROM_LAT = W6_ROM_LAT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] w6_raddr,
  output logic          w6_en,
  output logic [AW-1:0] x_raddr,
  output logic          x_en,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          mac_last
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_IN - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] addr;
  vtag_t         tag_in;
  vtag_t         tag_out;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (!stall && addr == LAST_ADDR) state_nxt = ST_DRAIN;
      // Final term is consumed in the cycle its tag reaches the pipe output
      ST_DRAIN: if (!stall && tag_out.valid && tag_out.last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;   // stall deliberately ignored here
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- address counter ----------------
  // Saturates at the last index so the address never wraps; cleared on the
  // way back to idle so the next pass starts at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (state == ST_RUN && !stall && addr != LAST_ADDR) begin
      addr <= addr + AW'(1);
    end else if (state == ST_DONE) begin
      addr <= '0;
    end
  end

  // ---------------- ROM-latency tag pipe ----------------
  // The address presented this cycle comes back as data ROM_LAT unstalled
  // cycles later; the pipe carries its valid/first/last tags alongside.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = (state == ST_RUN);
    tag_in.first = (state == ST_RUN) && (addr == '0);
    tag_in.last  = (state == ST_RUN) && (addr == LAST_ADDR);
  end

  valid_tag_pipe #(
    .DEPTH (ROM_LAT),
    .W     (VTAG_W)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (stall),
    .din   (tag_in),
    .dout  (tag_out)
  );

  // ---------------- outputs ----------------
  always_comb begin
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    w6_raddr = addr;
    x_raddr  = addr;
    // ROM and feature buffer advance together; a stall freezes both so the
    // in-flight data lines up with the frozen tag pipe on resume.
    w6_en    = busy && !stall;
    x_en     = busy && !stall;
    mac_en   = busy && !stall && tag_out.valid;
    mac_clr  = busy && !stall && tag_out.valid && tag_out.first;
    mac_last = busy && !stall && tag_out.valid && tag_out.last;
  end

endmodule
`default_nettype wire

// File: tb/tb_f6_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_f6_ctrl                                              |
// | Purpose  : Directed self-checking bench for f6_ctrl. Exercises the |
// |            default build (N_IN=120, ROM_LAT=2) plus two small      |
// |            builds (N_IN=5/ROM_LAT=1 and N_IN=1/ROM_LAT=3).         |
// | Ports    : none                                                    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_f6_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic stall;
  logic start0, start1, start2;

  logic       busy0, done0, we0, xe0, me0, mc0, ml0;
  logic [6:0] ra0, xa0;
  logic       busy1, done1, we1, xe1, me1, mc1, ml1;
  logic [2:0] ra1, xa1;
  logic       busy2, done2, we2, xe2, me2, mc2, ml2;
  logic [0:0] ra2, xa2;

  int n_checks = 0;
  int n_fails  = 0;

  f6_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stall(stall),
    .busy(busy0), .done(done0), .w6_raddr(ra0), .w6_en(we0),
    .x_raddr(xa0), .x_en(xe0), .mac_en(me0), .mac_clr(mc0), .mac_last(ml0)
  );

  f6_ctrl #(.N_IN(5), .AW(3), .ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stall(stall),
    .busy(busy1), .done(done1), .w6_raddr(ra1), .w6_en(we1),
    .x_raddr(xa1), .x_en(xe1), .mac_en(me1), .mac_clr(mc1), .mac_last(ml1)
  );

  f6_ctrl #(.N_IN(1), .AW(1), .ROM_LAT(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stall(stall),
    .busy(busy2), .done(done2), .w6_raddr(ra2), .w6_en(we2),
    .x_raddr(xa2), .x_en(xe2), .mac_en(me2), .mac_clr(mc2), .mac_last(ml2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int sel, input bit v);
    start0 = (sel == 0) && v;
    start1 = (sel == 1) && v;
    start2 = (sel == 2) && v;
  endtask

  task automatic sample(input int sel,
                        output logic [31:0] b, output logic [31:0] d,
                        output logic [31:0] we, output logic [31:0] xe,
                        output logic [31:0] me, output logic [31:0] mc,
                        output logic [31:0] ml, output logic [31:0] ra,
                        output logic [31:0] xa);
    case (sel)
      0: begin
        b = {31'b0, busy0}; d = {31'b0, done0}; we = {31'b0, we0}; xe = {31'b0, xe0};
        me = {31'b0, me0}; mc = {31'b0, mc0}; ml = {31'b0, ml0};
        ra = {25'b0, ra0}; xa = {25'b0, xa0};
      end
      1: begin
        b = {31'b0, busy1}; d = {31'b0, done1}; we = {31'b0, we1}; xe = {31'b0, xe1};
        me = {31'b0, me1}; mc = {31'b0, mc1}; ml = {31'b0, ml1};
        ra = {29'b0, ra1}; xa = {29'b0, xa1};
      end
      default: begin
        b = {31'b0, busy2}; d = {31'b0, done2}; we = {31'b0, we2}; xe = {31'b0, xe2};
        me = {31'b0, me2}; mc = {31'b0, mc2}; ml = {31'b0, ml2};
        ra = {31'b0, ra2}; xa = {31'b0, xa2};
      end
    endcase
  endtask

  task automatic check_all_zero(input int sel, input string tag);
    logic [31:0] b, d, we, xe, me, mc, ml, ra, xa;
    sample(sel, b, d, we, xe, me, mc, ml, ra, xa);
    check({tag, "_busy"}, b, 0);
    check({tag, "_done"}, d, 0);
    check({tag, "_w6_en"}, we, 0);
    check({tag, "_x_en"}, xe, 0);
    check({tag, "_mac_en"}, me, 0);
    check({tag, "_mac_clr"}, mc, 0);
    check({tag, "_mac_last"}, ml, 0);
    check({tag, "_w6_raddr"}, ra, 0);
    check({tag, "_x_raddr"}, xa, 0);
  endtask

  // One pass: start is driven in cycle 0, then every cycle is checked
  // against hand-derived timing. Progress p counts cycles in which the
  // sequencer advanced; e = p+1 is the equivalent stall-free cycle number.
  // Expected (stall-free, cycle e after start): addr e-1 up to N-1,
  // mac_en for e in [L+1, N+L], clr at L+1, last at N+L, done at N+L+1.
  // mode: 0 no stall, 1 stall for cycles lo..hi, 2 stall on odd cycles.
  task automatic run_pass(input int sel, input int n, input int l,
                          input int mode, input int lo, input int hi,
                          input bit poke, input int abort_at);
    logic [31:0] b, d, we, xe, me, mc, ml, ra, xa, idx;
    logic [31:0] q[$];
    int p, e, k, mac_cnt;
    int x_busy, x_done, x_we, x_me, x_mc, x_ml, x_ra;
    bit st, frz;

    next_cycle();
    set_start(sel, 1'b1);
    stall = 1'b0;
    #1;
    sample(sel, b, d, we, xe, me, mc, ml, ra, xa);
    check("c0_busy", b, 0);
    check("c0_mac_en", me, 0);

    p = 0; k = 0; mac_cnt = 0;
    while (p <= n + l + 1 && k < 2000) begin
      next_cycle();
      k++;
      e = p + 1;
      case (mode)
        0:       st = 1'b0;
        1:       st = (k >= lo) && (k <= hi);
        default: st = k[0];
      endcase
      set_start(sel, poke && (e == 10 || e == n + l + 1));
      stall = st;
      #1;
      sample(sel, b, d, we, xe, me, mc, ml, ra, xa);

      x_busy = (e <= n + l + 1) ? 1 : 0;
      x_done = (e == n + l + 1) ? 1 : 0;
      frz    = st && (x_busy == 1) && (x_done == 0);
      x_we   = (x_busy == 1 && !st) ? 1 : 0;
      x_me   = (!st && e >= l + 1 && e <= n + l) ? 1 : 0;
      x_mc   = (x_me == 1 && e == l + 1) ? 1 : 0;
      x_ml   = (x_me == 1 && e == n + l) ? 1 : 0;
      x_ra   = (e <= n) ? e - 1 : n - 1;

      check("busy", b, x_busy);
      check("done", d, x_done);
      check("w6_en", we, x_we);
      check("x_en", xe, x_we);
      check("mac_en", me, x_me);
      check("mac_clr", mc, x_mc);
      check("mac_last", ml, x_ml);
      if (x_busy == 1) begin
        check("w6_raddr", ra, x_ra);
        check("x_raddr", xa, x_ra);
      end

      // Scoreboard: issued address order must match MAC consumption order
      if (!st && e <= n) q.push_back(ra);
      if (me == 32'd1) begin
        if (q.size() == 0) begin
          check("sb_underflow", 32'd1, 0);
        end else begin
          idx = q.pop_front();
          check("sb_index", idx, mac_cnt);
          check("sb_clr", mc, (idx == 0) ? 1 : 0);
          check("sb_last", ml, (idx == n - 1) ? 1 : 0);
        end
        mac_cnt++;
      end

      if (!frz) p++;

      if (e == abort_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(sel, "abort");
        set_start(sel, 1'b0);
        stall = 1'b0;
        return;
      end
    end
    set_start(sel, 1'b0);
    stall = 1'b0;
    check("pass_bound", (k < 2000) ? 32'd1 : 32'd0, 1);
    check("mac_count", mac_cnt, n);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    set_start(0, 1'b0);
    start0 = 1'b0;
    repeat (3) next_cycle();
    check_all_zero(0, "rst0");
    check_all_zero(1, "rst1");
    check_all_zero(2, "rst2");
    rst_n = 1'b1;

    // Basic pass with start pulses at cycle 10 and at DONE (both ignored)
    run_pass(0, 120, 2, 0, 0, 0, 1'b1, 0);
    // Start two cycles after DONE: new pass with 5-cycle stall at 50..54
    run_pass(0, 120, 2, 1, 50, 54, 1'b0, 0);
    // Asynchronous reset mid-pass at cycle 60
    run_pass(0, 120, 2, 0, 0, 0, 1'b0, 60);
    next_cycle();
    check_all_zero(0, "in_rst");
    rst_n = 1'b1;
    next_cycle();
    check_all_zero(0, "post_rst");
    // Clean full pass after reset release
    run_pass(0, 120, 2, 0, 0, 0, 1'b0, 0);
    // Stall toggling every cycle
    run_pass(0, 120, 2, 2, 0, 0, 1'b0, 0);

    // Small builds
    run_pass(1, 5, 1, 0, 0, 0, 1'b0, 0);
    run_pass(1, 5, 1, 2, 0, 0, 1'b0, 0);
    run_pass(2, 1, 3, 0, 0, 0, 1'b0, 0);
    run_pass(2, 1, 3, 1, 2, 3, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
